// File: rtl/monitor_pkg.sv
// Shared types and constants for the output-signature monitor.
// Holds the FSM encoding, MISR polynomial/seed and the fold slicing widths.
package monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } mon_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // fold = y[15:0] ^ {pad, x[5:0], y[22:16]}
  localparam int FOLD_W     = 16;
  localparam int Y_LO_W     = 16;
  localparam int Y_HI_W     = 7;
  localparam int X_FOLD_W   = 6;
  localparam int FOLD_PAD_W = FOLD_W - X_FOLD_W - Y_HI_W;

endpackage

// File: rtl/misr16_step.sv
// One combinational MISR step: shift left with polynomial feedback, then
// absorb the folded controller vector.
module misr16_step
  import monitor_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [SIG_W-1:0] fold,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] feedback_s;

  assign feedback_s = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
  assign sig_next   = ({sig[SIG_W-2:0], 1'b0} ^ feedback_s) ^ fold;

endmodule

// File: rtl/out_sig_monitor.sv
// Controller output signature monitor: compacts a window of y/x transitions
// into a MISR signature, compares it with a golden value and watches zero runs.
module out_sig_monitor
  import monitor_pkg::*;
#(
  parameter int               Y_W      = 23,
  parameter int               X_W      = 6,
  parameter int               SIG_W    = 16,
  parameter int               ZERO_RUN = 3,
  parameter logic [SIG_W-1:0] POLY     = MISR_POLY,
  parameter logic [SIG_W-1:0] SEED     = MISR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       win_len,
  input  logic             in_valid,
  input  logic [Y_W-1:0]   y_vec,
  input  logic [X_W-1:0]   x_vec,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             mismatch,
  output logic [7:0]       zero_cnt,
  output logic             alarm
);

  localparam logic [7:0] ZRUN_MAX = 8'(ZERO_RUN);

  mon_state_e       state_r,    state_nx_s;
  logic [SIG_W-1:0] sig_r,      sig_nx_s;
  logic [7:0]       zero_cnt_r, zero_cnt_nx_s;
  logic [7:0]       zrun_r,     zrun_nx_s;
  logic             alarm_r,    alarm_nx_s;
  logic             mismatch_r, mismatch_nx_s;
  logic             done_r,     done_nx_s;
  logic             busy_r,     busy_nx_s;
  logic [8:0]       beat_r,     beat_nx_s;
  logic [8:0]       win_r,      win_nx_s;

  logic [SIG_W-1:0] fold_s;
  logic [SIG_W-1:0] misr_next_s;
  logic [8:0]       beat_inc_s;
  logic             zrun_full_s;

  assign fold_s = y_vec[Y_LO_W-1:0]
                ^ {{FOLD_PAD_W{1'b0}}, x_vec[X_FOLD_W-1:0], y_vec[Y_LO_W+Y_HI_W-1:Y_LO_W]};

  misr16_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .sig      (sig_r),
    .fold     (fold_s),
    .sig_next (misr_next_s)
  );

  assign beat_inc_s  = beat_r + 9'd1;
  assign zrun_full_s = (zrun_r == ZRUN_MAX);

  // Next-state and next-output computation for the capture FSM.
  always_comb begin
    state_nx_s    = state_r;
    sig_nx_s      = sig_r;
    zero_cnt_nx_s = zero_cnt_r;
    zrun_nx_s     = zrun_r;
    // alarm trails the zero-run counter by one cycle and stays set
    alarm_nx_s    = alarm_r | zrun_full_s;
    mismatch_nx_s = mismatch_r;
    done_nx_s     = 1'b0;
    beat_nx_s     = beat_r;
    win_nx_s      = win_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s    = ST_RUN;
          sig_nx_s      = SEED;
          zero_cnt_nx_s = 8'd0;
          zrun_nx_s     = 8'd0;
          alarm_nx_s    = 1'b0;
          mismatch_nx_s = 1'b0;
          beat_nx_s     = 9'd0;
          win_nx_s      = (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (in_valid) begin
          sig_nx_s  = misr_next_s;
          beat_nx_s = beat_inc_s;
          if (y_vec == {Y_W{1'b0}}) begin
            zero_cnt_nx_s = (zero_cnt_r == 8'hFF) ? 8'hFF : zero_cnt_r + 8'd1;
            zrun_nx_s     = (zrun_r >= ZRUN_MAX) ? ZRUN_MAX : zrun_r + 8'd1;
          end else begin
            zero_cnt_nx_s = zero_cnt_r;
            zrun_nx_s     = 8'd0;
          end
          if (beat_inc_s == win_r) begin
            state_nx_s = ST_CHECK;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_RUN;
            done_nx_s  = 1'b0;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end

      ST_CHECK: begin
        mismatch_nx_s = (sig_r != golden_sig);
        state_nx_s    = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sig_r      <= SEED;
      zero_cnt_r <= 8'd0;
      zrun_r     <= 8'd0;
      alarm_r    <= 1'b0;
      mismatch_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      beat_r     <= 9'd0;
      win_r      <= 9'd0;
    end else begin
      state_r    <= state_nx_s;
      sig_r      <= sig_nx_s;
      zero_cnt_r <= zero_cnt_nx_s;
      zrun_r     <= zrun_nx_s;
      alarm_r    <= alarm_nx_s;
      mismatch_r <= mismatch_nx_s;
      done_r     <= done_nx_s;
      busy_r     <= busy_nx_s;
      beat_r     <= beat_nx_s;
      win_r      <= win_nx_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sig      = sig_r;
  assign mismatch = mismatch_r;
  assign zero_cnt = zero_cnt_r;
  assign alarm    = alarm_r;

endmodule

// File: tb/tb_out_sig_monitor.sv
// Directed, table-driven bench for out_sig_monitor plus hand-written
// sequences for long windows, mid-window reset and held start.
module tb_out_sig_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  win_len;
  logic        in_valid;
  logic [22:0] y_vec;
  logic [5:0]  x_vec;
  logic [15:0] golden_sig;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic        mismatch;
  logic [7:0]  zero_cnt;
  logic        alarm;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0]        win;
    int                n;
    logic [7:0][22:0]  y;
    logic [7:0][5:0]   x;
    logic [15:0]       golden;
    logic [15:0]       exp_sig;
    logic [7:0]        exp_zero;
    logic              exp_alarm;
    logic              exp_mm;
  } vec_t;

  vec_t vt [9];

  out_sig_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .win_len    (win_len),
    .in_valid   (in_valid),
    .y_vec      (y_vec),
    .x_vec      (x_vec),
    .golden_sig (golden_sig),
    .busy       (busy),
    .done       (done),
    .sig        (sig),
    .mismatch   (mismatch),
    .zero_cnt   (zero_cnt),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [22:0] y,
                                             input logic [5:0] x);
    logic [15:0] f;
    logic [15:0] n;
    f = y[15:0] ^ {3'b000, x, y[22:16]};
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    return n ^ f;
  endfunction

  function automatic logic [15:0] win_sig(input vec_t v);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int b = 0; b < v.n; b++) s = misr_model(s, v.y[b], v.x[b]);
    return s;
  endfunction

  // hs != 0 supplies a hand-computed signature; otherwise the model is used
  function automatic vec_t mk(input logic [7:0] win, input int n,
                              input logic [22:0] y0, input logic [22:0] y1,
                              input logic [22:0] y2, input logic [22:0] y3,
                              input logic [22:0] y4, input logic [5:0] xc,
                              input logic [15:0] hs, input bit geq,
                              input logic [7:0] ez, input logic ea);
    vec_t v;
    v.win = win;
    v.n   = n;
    v.y   = '0;
    v.x   = '0;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2; v.y[3] = y3; v.y[4] = y4;
    for (int b = 0; b < 8; b++) v.x[b] = xc;
    v.exp_sig   = (hs != 16'h0000) ? hs : win_sig(v);
    v.golden    = geq ? v.exp_sig : 16'h0000;
    v.exp_mm    = !geq;
    v.exp_zero  = ez;
    v.exp_alarm = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gap_mode inserts b%4 idle cycles (with junk data) before beat b
  task automatic run_window(input vec_t v, input bit gap_mode, input string tag);
    int dones;
    dones    = 0;
    win_len  = v.win;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    for (int b = 0; b < v.n; b++) begin
      if (gap_mode) begin
        for (int g = 0; g < (b % 4); g++) begin
          in_valid = 1'b0;
          y_vec    = 23'h05A5A5;
          x_vec    = 6'h2A;
          tick();
          if (done) dones++;
        end
      end
      in_valid = 1'b1;
      y_vec    = v.y[b];
      x_vec    = v.x[b];
      tick();
      if (b < v.n - 1 && done) dones++;
    end
    in_valid = 1'b0;
    chk({tag, " early_done"}, dones, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " sig"}, {16'd0, sig}, {16'd0, v.exp_sig});
    golden_sig = v.golden;
    tick();
    chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " mismatch"}, {31'd0, mismatch}, {31'd0, v.exp_mm});
    chk({tag, " zero_cnt"}, {24'd0, zero_cnt}, {24'd0, v.exp_zero});
    chk({tag, " alarm"}, {31'd0, alarm}, {31'd0, v.exp_alarm});
  endtask

  initial begin
    vec_t        w;
    logic [15:0] es;
    int          dones;

    rst        = 1'b1;
    start      = 1'b0;
    win_len    = 8'd0;
    in_valid   = 1'b0;
    y_vec      = 23'd0;
    x_vec      = 6'd0;
    golden_sig = 16'd0;

    vt[0] = mk(8'd1, 1, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 6'd0, 16'hEFDF, 1'b1, 8'd1, 1'b0);
    vt[1] = mk(8'd1, 1, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 6'd0, 16'hEFDF, 1'b0, 8'd1, 1'b0);
    vt[2] = mk(8'd1, 1, 23'd1, 23'd0, 23'd0, 23'd0, 23'd0, 6'd0, 16'hEFDE, 1'b0, 8'd0, 1'b0);
    vt[3] = mk(8'd2, 2, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 6'd0, 16'hCF9F, 1'b1, 8'd2, 1'b0);
    vt[4] = mk(8'd5, 5, 23'd0, 23'd0, 23'd1, 23'd0, 23'd0, 6'd0, 16'h0000, 1'b1, 8'd4, 1'b0);
    vt[5] = mk(8'd5, 5, 23'd0, 23'd0, 23'd0, 23'd5, 23'd5, 6'd0, 16'h0000, 1'b0, 8'd3, 1'b1);
    vt[6] = mk(8'd1, 1, 23'h400000, 23'd0, 23'd0, 23'd0, 23'd0, 6'h3F, 16'hF01F, 1'b1, 8'd0, 1'b0);
    vt[7] = mk(8'd1, 1, 23'h7FFFFF, 23'd0, 23'd0, 23'd0, 23'd0, 6'd0, 16'h105F, 1'b1, 8'd0, 1'b0);
    vt[8] = mk(8'd4, 4, 23'h123456, 23'h000ABC, 23'd0, 23'h7F0001, 23'd0, 6'h15,
               16'h0000, 1'b1, 8'd1, 1'b0);

    // Reset state while rst is high
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst sig", {16'd0, sig}, 32'h0000FFFF);
    chk("rst mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst zero_cnt", {24'd0, zero_cnt}, 32'd0);
    chk("rst alarm", {31'd0, alarm}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_window(vt[i], 1'b0, $sformatf("vec%0d", i));

    // Same 4-beat window with 0..3 idle cycles between beats
    run_window(vt[8], 1'b1, "gap");

    // in_valid in IDLE must not disturb held results
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      y_vec    = 23'd0;
      x_vec    = 6'd7;
      tick();
    end
    in_valid = 1'b0;
    chk("idle sig_hold", {16'd0, sig}, {16'd0, vt[8].exp_sig});
    chk("idle zero_hold", {24'd0, zero_cnt}, 32'd1);
    chk("idle busy", {31'd0, busy}, 32'd0);

    // win_len=0 means 256 all-zero beats
    es = 16'hFFFF;
    for (int b = 0; b < 256; b++) es = misr_model(es, 23'd0, 6'd0);
    dones   = 0;
    win_len = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 256; b++) begin
      in_valid = 1'b1;
      y_vec    = 23'd0;
      x_vec    = 6'd0;
      tick();
      if (b < 255 && done) dones++;
    end
    in_valid = 1'b0;
    chk("w256 early_done", dones, 32'd0);
    chk("w256 done", {31'd0, done}, 32'd1);
    chk("w256 sig", {16'd0, sig}, {16'd0, es});
    golden_sig = es;
    tick();
    chk("w256 zero_cnt", {24'd0, zero_cnt}, 32'd255);
    chk("w256 alarm", {31'd0, alarm}, 32'd1);
    chk("w256 mismatch", {31'd0, mismatch}, 32'd0);

    // Reset after beat 2 of an 8-beat window
    win_len = 8'd8;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      y_vec    = 23'd0;
      x_vec    = 6'd1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst sig", {16'd0, sig}, 32'h0000FFFF);
    chk("midrst zero_cnt", {24'd0, zero_cnt}, 32'd0);
    chk("midrst alarm", {31'd0, alarm}, 32'd0);
    tick();
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      y_vec    = 23'd3;
      tick();
      if (done) dones++;
    end
    in_valid = 1'b0;
    chk("midrst no_done", dones, 32'd0);
    chk("midrst idle", {31'd0, busy}, 32'd0);
    w = mk(8'd8, 5, 23'd1, 23'd2, 23'd3, 23'd4, 23'd5, 6'h11, 16'h0000, 1'b1, 8'd0, 1'b0);
    w.n = 8;
    w.y[5] = 23'd6; w.y[6] = 23'd7; w.y[7] = 23'd8;
    w.exp_sig = win_sig(w);
    w.golden  = w.exp_sig;
    run_window(w, 1'b0, "after_rst");

    // start held high through RUN and CHECK
    dones   = 0;
    win_len = 8'd2;
    start   = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      y_vec    = 23'd9;
      x_vec    = 6'd0;
      tick();
      if (done) dones++;
    end
    in_valid = 1'b0;
    chk("hold one_done", dones, 32'd1);
    tick();
    chk("hold idle_gap", {31'd0, busy}, 32'd0);
    tick();
    chk("hold restart", {31'd0, busy}, 32'd1);
    start = 1'b0;
    dones = 0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      y_vec    = 23'd0;
      tick();
      if (b == 0 && done) dones++;
    end
    in_valid = 1'b0;
    chk("hold early_done2", dones, 32'd0);
    chk("hold done2", {31'd0, done}, 32'd1);
    tick();
    chk("hold zero2", {24'd0, zero_cnt}, 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
